// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: state encodings, default baud divisor.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  // 50 MHz / 115200 baud
  localparam int unsigned UART_TX_CLKS_PER_BIT = 434;
  localparam int unsigned BAUD_CNT_W           = 16;

  localparam logic [2:0] UART_TX_IDLE   = 3'd0;
  localparam logic [2:0] UART_TX_START  = 3'd1;
  localparam logic [2:0] UART_TX_DATA   = 3'd2;
  localparam logic [2:0] UART_TX_PARITY = 3'd3;
  localparam logic [2:0] UART_TX_STOP   = 3'd4;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    StIdle   = UART_TX_IDLE,
    StStart  = UART_TX_START,
    StData   = UART_TX_DATA,
    StParity = UART_TX_PARITY,
    StStop   = UART_TX_STOP
  } uart_tx_state_e;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [2:0] {
    StIdle  = UART_TX_IDLE,
    StStart = UART_TX_START,
    StData  = UART_TX_DATA,
    StStop  = UART_TX_STOP
  } uart_tx_state_e;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: 16-bit counter with synchronous clear, ticks on the last cycle of each bit.
module uart_baud_tick
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_TX_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam logic [BAUD_CNT_W-1:0] LastCount = BAUD_CNT_W'(CLKS_PER_BIT - 1);

  logic [BAUD_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == LastCount);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with registered tx/busyTx outputs.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_TX_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       txEnable,
  input  logic [7:0] txData,
  output logic       busyTx,
  output logic       tx
);

  uart_tx_state_e state_q;
  logic [7:0]     shift_q;
  logic [2:0]     bit_idx_q;
  logic [2:0]     bit_idx_next;
  logic           tx_q;
  logic           busy_q;
  logic           baud_clr;
  logic           baud_tick;

  // Holding the counter cleared while idle starts every frame at count 0.
  assign baud_clr     = (state_q == StIdle);
  assign bit_idx_next = bit_idx_q + 3'd1;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clr  (baud_clr),
    .tick (baud_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (txEnable) begin
            shift_q   <= txData;
            bit_idx_q <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= StStart;
          end
        end
        StStart: begin
          if (baud_tick) begin
            tx_q    <= shift_q[0];
            state_q <= StData;
          end
        end
        StData: begin
          if (baud_tick) begin
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= even_parity(shift_q);
              state_q <= StParity;
`else
              tx_q    <= 1'b1;
              state_q <= StStop;
`endif
            end else begin
              bit_idx_q <= bit_idx_next;
              tx_q      <= shift_q[bit_idx_next];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (baud_tick) begin
            tx_q    <= 1'b1;
            state_q <= StStop;
          end
        end
`endif
        StStop: begin
          // Falling busy is the only completion indication for the arbiter.
          if (baud_tick) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign tx     = tx_q;
  assign busyTx = busy_q;

endmodule
